// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word read per PC value over a req/gnt/rvalid
// handshake, holds the returned instruction for decode and pulses pc_en on acceptance.
module inst_fetch #(
    parameter logic [31:0] NOP     = 32'h0000_0013,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        inst_ready,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        inst_misaligned,
    output logic        pc_en,
    output logic        fetch_err
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_valid_q;
    logic        inst_misaligned_q;
    logic        fetch_err_q;
    logic        misaligned;

    assign misaligned = |pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (misaligned) begin
                    state_d = StHold;
                end else if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = imem_rvalid ? StReq : StDrop;
                end else if (imem_rvalid) begin
                    state_d = StHold;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    state_d = StReq;
                end
            end
            StHold: begin
                if (flush || inst_ready) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == StReq) && !misaligned;
        imem_addr = {pc[31:2], 2'b00};
        // flush wins over inst_ready so a redirected entry never advances the PC
        pc_en     = (state_q == StHold) && inst_ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q             <= 8'd0;
            inst_q            <= NOP;
            inst_pc_q         <= 32'd0;
            inst_valid_q      <= 1'b0;
            inst_misaligned_q <= 1'b0;
            fetch_err_q       <= 1'b0;
        end else begin
            case (state_q)
                StReq: begin
                    if (misaligned) begin
                        inst_q            <= NOP;
                        inst_pc_q         <= pc;
                        inst_valid_q      <= 1'b1;
                        inst_misaligned_q <= 1'b1;
                    end else if (imem_gnt) begin
                        inst_pc_q <= pc;
                        cnt_q     <= 8'd0;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (!flush) begin
                            inst_q            <= imem_rdata;
                            inst_valid_q      <= 1'b1;
                            inst_misaligned_q <= 1'b0;
                        end
                    end else begin
                        if (cnt_q == TimeoutLast) begin
                            fetch_err_q <= 1'b1;
                        end
                        // saturate rather than wrap while stuck waiting
                        if (cnt_q != 8'hff) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                StHold: begin
                    if (flush || inst_ready) begin
                        inst_q            <= NOP;
                        inst_valid_q      <= 1'b0;
                        inst_misaligned_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign inst_valid      = inst_valid_q;
    assign inst_misaligned = inst_misaligned_q;
    assign fetch_err       = fetch_err_q;

endmodule
